// File: rtl/mathfn_start_initiator_if.sv
// Bundle of signals between the job queue, the start initiator and one
// series-math core (Ln, exp, sin, cos).
//   req_*   : job request (valid/ready), operand and function select
//   core_*  : operand, select and start going to the core; Ready and result
//             coming back from it
//   rsp_*   : result response (valid/ready), captured data and error flag
// Modports:
//   master : the start initiator
//   slave  : the environment (job queue, core and response consumer)
interface mathfn_start_initiator_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_x;
  logic [1:0]       req_sel;
  logic [WIDTH-1:0] core_x;
  logic [1:0]       core_sel;
  logic             core_start;
  logic             core_ready;
  logic [WIDTH-1:0] core_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    input  req_valid, req_x, req_sel, core_ready, core_result, rsp_ready,
    output req_ready, core_x, core_sel, core_start, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output req_valid, req_x, req_sel, core_ready, core_result, rsp_ready,
    input  req_ready, core_x, core_sel, core_start, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mathfn_start_initiator.sv
// Requester-side controller for the start/Ready handshake of one series-math
// core. Takes one job at a time, pulses core_start for START_W cycles, follows
// the core's Ready fall and rise, captures core_result and offers it on the
// response port.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous, active-high reset
//   bus   : mathfn_start_initiator_if.master (request, core and response sides)
//
// Optional feature: define MATHFN_INIT_TIMEOUT_EN to add a saturating timeout
// counter. When it reaches TIMEOUT cycles after start release without Ready
// re-rising, the job is answered with rsp_err=1 and rsp_data=0. Without the
// macro the controller waits indefinitely and rsp_err is always 0.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no job; req_ready follows core_ready
// PULSE     | core_start high, START_W cycles
// WAIT_BUSY | start released, waiting to see Ready low
// BUSY      | core running, waiting for Ready to rise
// RESP      | response offered, waiting for rsp_ready
module mathfn_start_initiator #(
  parameter int WIDTH   = 16,
  parameter int START_W = 2,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  mathfn_start_initiator_if.master bus
);

  if ((START_W < 1) || (START_W > 15)) begin : g_bad_start_w
    $error("START_W must be in 1..15");
  end
  if ((2 ** TO_W) <= TIMEOUT) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT");
  end

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    WAIT_BUSY,
    BUSY,
    RESP
  } state_t;

  localparam logic [3:0] START_LAST = 4'(START_W - 1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       start_cnt;
  logic             busy_seen;
  logic [WIDTH-1:0] core_x_q;
  logic [1:0]       core_sel_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic             req_ready_c;
  logic             accept;
  logic             capture;
  logic             timed_out;
  logic             to_hit;

`ifdef MATHFN_INIT_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt;

  // to_cnt holds the cycles already spent in WAIT_BUSY/BUSY, so the cycle
  // where it equals TIMEOUT-1 is the TIMEOUT-th one; the counter reaches
  // TIMEOUT on the same edge that enters RESP, and rsp_valid appears exactly
  // TIMEOUT cycles after start release.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == PULSE) begin
      to_cnt <= '0;
    end else if (((state == WAIT_BUSY) || (state == BUSY)) && (to_cnt != TO_MAX)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (to_cnt == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  // req_ready is held low during the reset cycle itself.
  assign req_ready_c = (state == IDLE) && bus.core_ready && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid && req_ready_c) begin
          accept    = 1'b1;
          state_nxt = PULSE;
        end
      end
      PULSE: begin
        if (start_cnt == 4'd0) begin
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // A core that already dropped and re-raised Ready during the pulse has
        // finished; let BUSY capture it instead of timing out.
        if (to_hit && !(busy_seen && bus.core_ready)) begin
          timed_out = 1'b1;
          state_nxt = RESP;
        end else if (busy_seen || !bus.core_ready) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.core_ready) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else if (to_hit) begin
          timed_out = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_x_q   <= '0;
      core_sel_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      busy_seen  <= 1'b0;
      start_cnt  <= '0;
    end else begin
      if (accept) begin
        core_x_q   <= bus.req_x;
        core_sel_q <= bus.req_sel;
        busy_seen  <= 1'b0;
        start_cnt  <= START_LAST;
      end
      if (state == PULSE) begin
        if (!bus.core_ready) begin
          busy_seen <= 1'b1;
        end
        if (start_cnt != 4'd0) begin
          start_cnt <= start_cnt - 1'b1;
        end
      end
      if (capture) begin
        rsp_data_q <= bus.core_result;
        rsp_err_q  <= 1'b0;
      end
      if (timed_out) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b1;
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.core_start = (state == PULSE);
  assign bus.core_x     = core_x_q;
  assign bus.core_sel   = core_sel_q;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_mathfn_start_initiator.sv
// Self-checking bench for mathfn_start_initiator. Two instances share one
// behavioural core model: dut0 with START_W=2 and dut1 with START_W=1, both
// with TIMEOUT=50. The model result is core_x ^ {core_sel, 14'h0}.
module tb_mathfn_start_initiator;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  mathfn_start_initiator_if #(.WIDTH(WIDTH)) bus0 ();
  mathfn_start_initiator_if #(.WIDTH(WIDTH)) bus1 ();

  mathfn_start_initiator #(.WIDTH(WIDTH), .START_W(2), .TIMEOUT(50), .TO_W(10)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  mathfn_start_initiator #(.WIDTH(WIDTH), .START_W(1), .TIMEOUT(50), .TO_W(10)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  logic             req_valid   [2];
  logic [15:0]      req_x       [2];
  logic [1:0]       req_sel     [2];
  logic             rsp_ready   [2];
  logic             core_ready  [2] = '{1'b1, 1'b1};
  logic [15:0]      core_result [2] = '{16'h0, 16'h0};
  logic             req_ready   [2];
  logic [15:0]      core_x      [2];
  logic [1:0]       core_sel    [2];
  logic             core_start  [2];
  logic             rsp_valid   [2];
  logic [15:0]      rsp_data    [2];
  logic             rsp_err     [2];

  assign bus0.req_valid = req_valid[0];     assign bus1.req_valid = req_valid[1];
  assign bus0.req_x = req_x[0];             assign bus1.req_x = req_x[1];
  assign bus0.req_sel = req_sel[0];         assign bus1.req_sel = req_sel[1];
  assign bus0.rsp_ready = rsp_ready[0];     assign bus1.rsp_ready = rsp_ready[1];
  assign bus0.core_ready = core_ready[0];   assign bus1.core_ready = core_ready[1];
  assign bus0.core_result = core_result[0]; assign bus1.core_result = core_result[1];
  assign req_ready[0] = bus0.req_ready;     assign req_ready[1] = bus1.req_ready;
  assign core_x[0] = bus0.core_x;           assign core_x[1] = bus1.core_x;
  assign core_sel[0] = bus0.core_sel;       assign core_sel[1] = bus1.core_sel;
  assign core_start[0] = bus0.core_start;   assign core_start[1] = bus1.core_start;
  assign rsp_valid[0] = bus0.rsp_valid;     assign rsp_valid[1] = bus1.rsp_valid;
  assign rsp_data[0] = bus0.rsp_data;       assign rsp_data[1] = bus1.rsp_data;
  assign rsp_err[0] = bus0.rsp_err;         assign rsp_err[1] = bus1.rsp_err;

  // Core model: Ready drops while start is seen, stays low busy_len cycles
  // after start falls, then rises with the result. m_stuck freezes it busy;
  // m_hold keeps an idle core's Ready low.
  int          busy_len = 4;
  bit          m_stuck  = 1'b0;
  bit          m_hold   [2] = '{1'b0, 1'b0};
  bit          m_busy   [2] = '{1'b0, 1'b0};
  int          m_cnt    [2] = '{0, 0};
  logic [15:0] m_res    [2] = '{16'h0, 16'h0};
  logic        prev_s   [2] = '{1'b0, 1'b0};
  int          n_starts [2] = '{0, 0};
  int          viol = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      prev_s[k] <= core_start[k];
      if (core_start[k]) begin
        if (!prev_s[k]) begin
          n_starts[k] <= n_starts[k] + 1;
          if (!core_ready[k]) viol <= viol + 1;
        end
        m_busy[k]     <= 1'b1;
        m_cnt[k]      <= busy_len;
        m_res[k]      <= core_x[k] ^ {core_sel[k], 14'h0};
        core_ready[k] <= 1'b0;
      end else if (m_busy[k]) begin
        if (!m_stuck) begin
          if (m_cnt[k] <= 1) begin
            m_busy[k]      <= 1'b0;
            core_ready[k]  <= 1'b1;
            core_result[k] <= m_res[k];
          end else begin
            m_cnt[k] <= m_cnt[k] - 1;
          end
        end
      end else begin
        core_ready[k] <= !m_hold[k];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first low-start cycle.
  task automatic submit(input int k, input logic [15:0] x, input logic [1:0] sel,
                        output int plen);
    int n;
    n = 0;
    req_valid[k] = 1'b1;
    req_x[k]     = x;
    req_sel[k]   = sel;
    while (!req_ready[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("accept_bound", 32'(n), 32'd0);
    @(negedge clk);
    req_valid[k] = 1'b0;
    chk("core_x", 32'(core_x[k]), 32'(x));
    chk("core_sel", 32'(core_sel[k]), 32'(sel));
    plen = 0;
    while (core_start[k] && plen < 20) begin
      plen++;
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(input int k, input int limit, output int cyc, output bit got);
    cyc = 0;
    while (!rsp_valid[k] && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    got = rsp_valid[k];
  endtask

  task automatic take_rsp(input int k, input logic [15:0] exp_d, input logic exp_e);
    chk("take_valid", 32'(rsp_valid[k]), 32'd1);
    chk("take_data", 32'(rsp_data[k]), 32'(exp_d));
    chk("take_err", 32'(rsp_err[k]), 32'(exp_e));
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    chk("take_drop", 32'(rsp_valid[k]), 32'd0);
  endtask

  typedef struct {
    logic [15:0] x;
    logic [1:0]  sel;
    int          blen;
    int          hold;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [4];
  logic [15:0] bx   [4];
  logic [1:0]  bsel [4];
  logic [15:0] bexp [4];

  initial begin
    int plen, cyc, i, ready_at, rr_bad, s0;
    bit got, ok, stable;

    vecs[0] = '{x: 16'h1234, sel: 2'd1, blen: 20, hold: 0,  exp: 16'h5234};
    vecs[1] = '{x: 16'hABCD, sel: 2'd2, blen: 5,  hold: 10, exp: 16'h2BCD};
    vecs[2] = '{x: 16'h0000, sel: 2'd3, blen: 1,  hold: 2,  exp: 16'hC000};
    vecs[3] = '{x: 16'hFFFF, sel: 2'd0, blen: 3,  hold: 0,  exp: 16'hFFFF};
    bx[0] = 16'h0001; bsel[0] = 2'd0; bexp[0] = 16'h0001;
    bx[1] = 16'h8000; bsel[1] = 2'd1; bexp[1] = 16'hC000;
    bx[2] = 16'h7FFF; bsel[2] = 2'd2; bexp[2] = 16'hFFFF;
    bx[3] = 16'h1357; bsel[3] = 2'd3; bexp[3] = 16'hD357;

    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_x[k]     = 16'h0;
      req_sel[k]   = 2'd0;
      rsp_ready[k] = 1'b0;
    end

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
    chk("rst_start", 32'(core_start[0]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data[0]), 32'd0);
    chk("rst_core_x", 32'(core_x[0]), 32'd0);
    chk("rst_core_sel", 32'(core_sel[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready[0]), 32'd1);

    // Basic jobs and response backpressure
    for (int v = 0; v < 4; v++) begin
      busy_len = vecs[v].blen;
      submit(0, vecs[v].x, vecs[v].sel, plen);
      chk("start_width", 32'(plen), 32'd2);
      ready_at = -1;
      i        = 0;
      rr_bad   = 0;
      while (!rsp_valid[0] && i < 200) begin
        if (core_ready[0] && ready_at < 0) ready_at = i;
        if (req_ready[0]) rr_bad++;
        @(negedge clk);
        i++;
      end
      chk("rsp_latency", 32'(i), 32'(vecs[v].blen + 1));
      chk("ready_to_rsp", 32'(i - ready_at), 32'd1);
      stable = 1'b1;
      req_valid[0] = 1'b1;
      req_x[0]     = 16'hDEAD;
      for (int h = 0; h < vecs[v].hold; h++) begin
        if (!rsp_valid[0] || rsp_data[0] !== vecs[v].exp || req_ready[0]) stable = 1'b0;
        @(negedge clk);
      end
      req_valid[0] = 1'b0;
      chk("rsp_stable", 32'(stable), 32'd1);
      chk("busy_req_ready", 32'(rr_bad), 32'd0);
      take_rsp(0, vecs[v].exp, 1'b0);
      chk("next_req_ready", 32'(req_ready[0]), 32'd1);
    end

    // Core busy when the request arrives
    busy_len  = 4;
    m_hold[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_x[0]     = 16'h5555;
    req_sel[0]   = 2'd1;
    ok = 1'b1;
    repeat (5) begin
      if (req_ready[0] || core_start[0]) ok = 1'b0;
      @(negedge clk);
    end
    chk("busy_no_accept", 32'(ok), 32'd1);
    m_hold[0] = 1'b0;
    chk("still_blocked", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    chk("ready_accept", 32'(req_ready[0]), 32'd1);
    chk("no_early_start", 32'(core_start[0]), 32'd0);
    @(negedge clk);
    chk("start_after_busy", 32'(core_start[0]), 32'd1);
    req_valid[0] = 1'b0;
    wait_rsp(0, 100, cyc, got);
    take_rsp(0, 16'h1555, 1'b0);

    // Core never raises Ready
    m_stuck  = 1'b1;
    busy_len = 5;
    submit(0, 16'h0F0F, 2'd2, plen);
    wait_rsp(0, 120, cyc, got);
`ifdef MATHFN_INIT_TIMEOUT_EN
    chk("to_valid", 32'(got), 32'd1);
    chk("to_cycles", 32'(cyc), 32'd50);
    take_rsp(0, 16'h0000, 1'b1);
    m_stuck = 1'b0;
`else
    chk("no_rsp_stuck", 32'(got), 32'd0);
    m_stuck = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    i = 0;
    while (!core_ready[0] && i < 60) begin
      @(negedge clk);
      i++;
    end

    // Reset mid-BUSY
    busy_len = 30;
    submit(0, 16'h2222, 2'd3, plen);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstcyc_req_ready", 32'(req_ready[0]), 32'd0);
    rst = 1'b0;
    chk("mid_rst_start", 32'(core_start[0]), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid[0]), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready[0]), 32'(core_ready[0]));
    ok = 1'b1;
    i  = 0;
    while (!core_ready[0] && i < 60) begin
      if (rsp_valid[0]) ok = 1'b0;
      @(negedge clk);
      i++;
    end
    chk("discard_partial", 32'(ok), 32'd1);
    busy_len = 3;
    submit(0, 16'h3333, 2'd1, plen);
    wait_rsp(0, 100, cyc, got);
    take_rsp(0, 16'h7333, 1'b0);

    // Back-to-back on START_W=1 instance
    busy_len     = 2;
    rsp_ready[1] = 1'b1;
    s0           = n_starts[1];
    for (int j = 0; j < 4; j++) begin
      submit(1, bx[j], bsel[j], plen);
      chk("b2b_width", 32'(plen), 32'd1);
      wait_rsp(1, 100, cyc, got);
      chk("b2b_valid", 32'(got), 32'd1);
      chk("b2b_data", 32'(rsp_data[1]), 32'(bexp[j]));
      @(negedge clk);
    end
    rsp_ready[1] = 1'b0;
    chk("b2b_starts", 32'(n_starts[1] - s0), 32'd4);
    chk("start_while_busy", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
